// File: rtl/icache_refill_mem.sv
// Memory-side refill responder for the I-cache: fixed access latency, four-beat word
// burst from an internal RAM, then a one-cycle mem_ready with the assembled 128-bit line.
`timescale 1ns/1ps
module icache_refill_mem #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_r,
  input  logic [31:0]              mem_addr,
  output logic                     mem_ready,
  output logic [127:0]             mem_data,
  output logic                     mem_err,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [2:0] {IDLE, WAIT, BURST, DONE, HOLD} state_t;

  logic [31:0]   ram [DEPTH];
  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_last;
  logic [1:0]    beat;
  logic [AW-3:0] base;
  logic          err;
  logic [95:0]   line;
  logic          req_err;
  logic [31:0]   rd_word;
  logic          unused_addr_bits;

  // Loader writes land at the edge; a same-edge beat capture sees the old word.
  always_ff @(posedge clk) begin
    if (ld_we) ram[ld_addr] <= ld_data;
  end

  assign req_err          = |mem_addr[31:AW+2];
  assign rd_word          = ram[{base, beat}];
  assign unused_addr_bits = ^mem_addr[3:0];

  // Error requests spend one extra WAIT edge so they answer after edge LATENCY+1.
  assign wait_last = err ? CW'(LATENCY) : CW'(LATENCY - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_data  <= '0;
      wait_cnt  <= '0;
      beat      <= '0;
      base      <= '0;
      err       <= 1'b0;
      line      <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        // The DONE exit edge ignores mem_r (stale request); the HOLD exit edge is the
        // first to see the cache's follow-up request and may launch it directly.
        IDLE, HOLD: begin
          if (mem_r) begin
            base     <= mem_addr[AW+1:4];
            err      <= req_err;
            wait_cnt <= '0;
            beat     <= '0;
            state    <= (LATENCY > 0 || req_err) ? WAIT : BURST;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == wait_last) begin
            if (err) begin
              mem_ready <= 1'b1;
              mem_err   <= 1'b1;
              mem_data  <= '0;
              state     <= DONE;
            end else begin
              state <= BURST;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        BURST: begin
          beat <= beat + 2'd1;
          case (beat)
            2'd0: line[31:0]  <= rd_word;
            2'd1: line[63:32] <= rd_word;
            2'd2: line[95:64] <= rd_word;
            default: begin
              mem_ready <= 1'b1;
              mem_err   <= 1'b0;
              mem_data  <= {rd_word, line};
              state     <= DONE;
            end
          endcase
        end
        DONE:    state <= HOLD;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_mem.sv
// Self-checking bench for icache_refill_mem: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a word-array reference model.
`timescale 1ns/1ps
module tb_icache_refill_mem;

  localparam int DEPTH = 1024;
  localparam int L     = 2;
  localparam int AW    = 10;

  logic          clk;
  logic          rst;
  logic          mem_r;
  logic [31:0]   mem_addr;
  logic          mem_ready;
  logic [127:0]  mem_data;
  logic          mem_err;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  logic [31:0] model_mem [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0]  addr;
    logic         exp_err;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  icache_refill_mem #(.DEPTH(DEPTH), .LATENCY(L), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .mem_r(mem_r), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data), .mem_err(mem_err),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input int unsigned a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    tick();
    ld_we = 1'b0;
    model_mem[a] = d;
  endtask

  function automatic logic [31:0] pat(input int unsigned i);
    return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [127:0] line_of(input int unsigned ln);
    return {model_mem[ln*4+3], model_mem[ln*4+2], model_mem[ln*4+1], model_mem[ln*4]};
  endfunction

  // Request sampled at edge 0; ready expected only after edge LATENCY+4 (LATENCY+1 on error).
  task automatic run_txn(input string name, input logic [31:0] addr,
                         input logic exp_err, input logic [127:0] exp_data);
    int rdy;
    rdy = exp_err ? L + 1 : L + 4;
    mem_r    = 1'b1;
    mem_addr = addr;
    for (int e = 0; e <= rdy; e++) begin
      tick();
      chk($sformatf("%s_rdy_e%0d", name, e), mem_ready, (e == rdy));
    end
    chk({name, "_err"}, mem_err, exp_err);
    chk({name, "_data"}, mem_data, exp_data);
    mem_r    = 1'b0;
    mem_addr = $urandom;
    tick();
    chk({name, "_pulse"}, mem_ready, 1'b0);
    tick();
  endtask

  initial begin
    logic [127:0] exp_a;
    logic [127:0] exp_b;
    logic [31:0]  a;
    logic         e_err;
    int           ln;
    int           rdy;
    int           extra;
    logic [31:0]  cap [4];

    rst = 1'b1; mem_r = 1'b0; mem_addr = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) tick();
    chk("reset_ready", mem_ready, 1'b0);
    chk("reset_err", mem_err, 1'b0);
    chk("reset_data", mem_data, 128'h0);
    rst = 1'b0;
    tick();

    for (int unsigned i = 0; i < DEPTH; i++) ld_write(i, pat(i));
    ld_write(32'h40, 32'h1111_1111);
    ld_write(32'h41, 32'h2222_2222);
    ld_write(32'h42, 32'h3333_3333);
    ld_write(32'h43, 32'h4444_4444);

    vecs[0] = '{32'h0000_0104, 1'b0, 128'h44444444_33333333_22222222_11111111};
    vecs[1] = '{32'hFFFF_FFF0, 1'b1, 128'h0};
    vecs[2] = '{32'h0000_0000, 1'b0, line_of(0)};
    vecs[3] = '{32'h0000_0FFC, 1'b0, line_of(255)};
    vecs[4] = '{32'h0000_1000, 1'b1, 128'h0};
    vecs[5] = '{32'h0000_010F, 1'b0, 128'h44444444_33333333_22222222_11111111};
    vecs[6] = '{32'h0000_0020, 1'b0, line_of(2)};
    for (int i = 0; i < 7; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_err, vecs[i].exp_data);

    // Back-to-back with mem_r held and the address switched during HOLD.
    exp_a = line_of(16);
    exp_b = line_of(32);
    mem_r = 1'b1; mem_addr = 32'h100;
    for (int e = 0; e <= 14; e++) begin
      tick();
      chk($sformatf("b2b_rdy_e%0d", e), mem_ready, (e == 6 || e == 14));
      if (e == 6) chk("b2b_line0", mem_data, exp_a);
      if (e == 7) mem_addr = 32'h200;
      if (e == 14) begin
        chk("b2b_line1", mem_data, exp_b);
        mem_r = 1'b0;
      end
    end
    tick(); tick();

    // Loader write to word 0x42 on the beat-2 capture edge.
    exp_a = line_of(16);
    mem_r = 1'b1; mem_addr = 32'h100;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 4) begin ld_we = 1'b1; ld_addr = 10'h42; ld_data = 32'hDEAD_BEEF; end
      if (e == 5) ld_we = 1'b0;
      if (e == 6) begin
        chk("wr_race_rdy", mem_ready, 1'b1);
        chk("wr_race_old", mem_data, exp_a);
      end
    end
    model_mem[32'h42] = 32'hDEAD_BEEF;
    mem_r = 1'b0;
    tick(); tick();
    run_txn("wr_new", 32'h100, 1'b0, line_of(16));

    // Reset asserted on the beat-2 capture edge.
    mem_r = 1'b1; mem_addr = 32'h100;
    for (int e = 0; e <= 4; e++) tick();
    rst = 1'b1; mem_r = 1'b0;
    tick();
    chk("midrst_ready", mem_ready, 1'b0);
    chk("midrst_data", mem_data, 128'h0);
    chk("midrst_err", mem_err, 1'b0);
    rst = 1'b0;
    tick();
    run_txn("post_rst", 32'h200, 1'b0, line_of(32));

    // Address changed during WAIT: latched line served, no second transaction.
    mem_r = 1'b1; mem_addr = 32'h100;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 1) mem_addr = 32'h300;
      if (e == 6) begin
        chk("addr_chg_rdy", mem_ready, 1'b1);
        chk("addr_chg_line", mem_data, line_of(16));
        mem_r = 1'b0;
      end
    end
    extra = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (mem_ready) extra++;
    end
    chk("addr_chg_no_second", 128'(extra), 128'h0);

    // Randomized transactions with random loader traffic and don't-care request churn.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom_range(32'hFFFF_FFFF, 32'h1000);
      else                           a = $urandom_range(32'hFFF, 0);
      e_err = (a >> 2) >= DEPTH;
      ln    = int'(a >> 4);
      rdy   = e_err ? L + 1 : L + 4;
      for (int e = 0; e <= rdy + 2; e++) begin
        if (e == 0) begin
          mem_r = 1'b1; mem_addr = a;
        end else if (e == rdy + 2) begin
          mem_r = 1'b0;
        end else begin
          mem_r = 1'($urandom_range(1, 0)); mem_addr = $urandom;
        end
        ld_we   = 1'($urandom_range(1, 0));
        ld_addr = ($urandom_range(1, 0) == 1) ? AW'(ln * 4 + int'($urandom_range(3, 0)))
                                              : AW'($urandom_range(DEPTH - 1, 0));
        ld_data = $urandom;
        @(posedge clk);
        if (!e_err && e >= L + 1 && e <= L + 4) cap[e-L-1] = model_mem[ln*4 + e-L-1];
        if (ld_we) model_mem[ld_addr] = ld_data;
        #1;
        chk($sformatf("rnd%0d_rdy_e%0d", t, e), mem_ready, (e == rdy));
        if (e == rdy) begin
          chk($sformatf("rnd%0d_err", t), mem_err, e_err);
          chk($sformatf("rnd%0d_data", t), mem_data,
              e_err ? 128'h0 : {cap[3], cap[2], cap[1], cap[0]});
        end
      end
      ld_we = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
